// File: rtl/acoustics_uart_pkg.sv
// rtl/acoustics_uart_pkg.sv - shared UART types and constants for the acoustics host link
package acoustics_uart_pkg;

  localparam int UART_DEFAULT_CLKS_PER_BIT = 868;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    BREAK
  } uart_rx_state_t;

endpackage

// File: rtl/uart_rx_line_sync.sv
// rtl/uart_rx_line_sync.sv - 2-FF synchroniser with history FF and falling-edge flag
module uart_rx_line_sync (
  input  logic clk,
  input  logic reset_b,
  input  logic line,
  output logic line_s,
  output logic fall
);

  logic line_meta;
  logic line_d;

  // Reset to the idle-high level so a reset never fabricates an edge on a quiet line.
  always_ff @(posedge clk) begin
    if (!reset_b) begin
      line_meta <= 1'b1;
      line_s    <= 1'b1;
      line_d    <= 1'b1;
    end else begin
      line_meta <= line;
      line_s    <= line_meta;
      line_d    <= line_s;
    end
  end

  assign fall = line_d & ~line_s;

endmodule

// File: rtl/uart_command_receiver.sv
// rtl/uart_command_receiver.sv - oversampling 8N1 receiver presenting good bytes with a ready strobe
module uart_command_receiver
  import acoustics_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = UART_DEFAULT_CLKS_PER_BIT
) (
  input  logic       clk,
  input  logic       reset_b,
  input  logic       RsRx,
  output logic [7:0] Command,
  output logic       Rx_Ready,
  output logic       Framing_Error,
  output logic       Rx_Busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  uart_rx_state_t state;
  logic [CW-1:0]  cnt;
  logic [2:0]     bit_idx;
  logic [7:0]     shreg;
  logic           rx_s;
  logic           rx_fall;

  uart_rx_line_sync u_line_sync (
    .clk     (clk),
    .reset_b (reset_b),
    .line    (RsRx),
    .line_s  (rx_s),
    .fall    (rx_fall)
  );

  always_ff @(posedge clk) begin
    if (!reset_b) begin
      state         <= IDLE;
      cnt           <= '0;
      bit_idx       <= '0;
      shreg         <= '0;
      Command       <= 8'h00;
      Rx_Ready      <= 1'b0;
      Framing_Error <= 1'b0;
      Rx_Busy       <= 1'b0;
    end else begin
      Rx_Ready      <= 1'b0;
      Framing_Error <= 1'b0;
      case (state)
        IDLE: begin
          if (rx_fall) begin
            cnt     <= '0;
            state   <= START;
            Rx_Busy <= 1'b1;
          end
        end
        // Re-check the line half a bit in so short low glitches are discarded.
        START: begin
          if (cnt == HALF_LAST) begin
            cnt     <= '0;
            bit_idx <= '0;
            if (!rx_s) begin
              state <= DATA;
            end else begin
              state   <= IDLE;
              Rx_Busy <= 1'b0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DATA: begin
          if (cnt == BIT_LAST) begin
            cnt            <= '0;
            shreg[bit_idx] <= rx_s;
            if (bit_idx == 3'd7) begin
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 1'b1;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        // Leaving at mid stop bit gives half a bit of slack for back-to-back frames.
        STOP: begin
          if (cnt == BIT_LAST) begin
            cnt <= '0;
            if (rx_s) begin
              Command  <= shreg;
              Rx_Ready <= 1'b1;
              Rx_Busy  <= 1'b0;
              state    <= IDLE;
            end else begin
              Framing_Error <= 1'b1;
              state         <= BREAK;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        BREAK: begin
          if (rx_s) begin
            state   <= IDLE;
            Rx_Busy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          Rx_Busy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_command_receiver.sv
// tb/tb_uart_command_receiver.sv - randomized self-checking bench for uart_command_receiver
module tb_uart_command_receiver;

  localparam int C      = 16;
  localparam int H      = C / 2;
  localparam int BIT_NS = C * 10;

  typedef struct {
    logic       is_err;
    logic [7:0] data;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       reset_b;
  logic       RsRx;
  logic [7:0] Command;
  logic       Rx_Ready;
  logic       Framing_Error;
  logic       Rx_Busy;

  int         cyc;
  int         n_vec;
  int         n_err;
  logic [7:0] model_cmd;
  exp_t       exp_q[$];

  uart_command_receiver #(.CLKS_PER_BIT(C)) dut (
    .clk           (clk),
    .reset_b       (reset_b),
    .RsRx          (RsRx),
    .Command       (Command),
    .Rx_Ready      (Rx_Ready),
    .Framing_Error (Framing_Error),
    .Rx_Busy       (Rx_Busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  // Line pulses low shortly after a negedge so every bit change stays clear of posedges.
  task automatic align();
    @(negedge clk);
    #2;
  endtask

  task automatic send_raw(input logic [7:0] b, input logic stop, input int bit_ns);
    logic [9:0] bits;
    bits = {stop, b, 1'b0};
    for (int i = 0; i < 10; i++) begin
      RsRx = bits[i];
      #(bit_ns);
    end
  endtask

  // Reference: a frame ends in a ready (stop=1) or an error (stop=0), reported one
  // cycle after the stop sample at pin + 3 sync cycles + H + 9 bit periods.
  task automatic send_frame(input logic [7:0] b, input logic stop, input int bit_ns);
    exp_t e;
    e.is_err = ~stop;
    e.data   = b;
    e.cyc    = (bit_ns == BIT_NS) ? cyc + 2 + H + 9 * C + 1 : -1;
    exp_q.push_back(e);
    send_raw(b, stop, bit_ns);
  endtask

  always @(negedge clk) begin
    if (reset_b && (Rx_Ready || Framing_Error)) begin
      check("exclusive", {31'd0, Rx_Ready & Framing_Error}, 32'd0);
      if (exp_q.size() == 0) begin
        check("spurious_pulse", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("pulse_kind", {31'd0, Framing_Error}, {31'd0, e.is_err});
        if (!e.is_err) begin
          check("command", {24'd0, Command}, {24'd0, e.data});
          model_cmd = e.data;
        end else begin
          check("cmd_hold_on_error", {24'd0, Command}, {24'd0, model_cmd});
        end
        if (e.cyc >= 0) check("pulse_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int g;
    int sel;
    int gap;
    logic [7:0] b;

    n_vec     = 0;
    n_err     = 0;
    model_cmd = 8'h00;
    RsRx      = 1'b1;
    reset_b   = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    check("rst_command", {24'd0, Command}, 32'h00);
    check("rst_ready", {31'd0, Rx_Ready}, 32'd0);
    check("rst_ferr", {31'd0, Framing_Error}, 32'd0);
    check("rst_busy", {31'd0, Rx_Busy}, 32'd0);
    reset_b = 1'b1;
    repeat (5) @(negedge clk);

    align();
    send_frame(8'hA5, 1'b1, BIT_NS);
    repeat (20) @(negedge clk);
    check("a5_busy_idle", {31'd0, Rx_Busy}, 32'd0);

    align();
    send_frame(8'h00, 1'b1, BIT_NS);
    send_frame(8'hFF, 1'b1, BIT_NS);
    send_frame(8'h3C, 1'b1, BIT_NS);
    repeat (20) @(negedge clk);

    align();
    g = cyc;
    RsRx = 1'b0;
    #50;
    RsRx = 1'b1;
    while (cyc < g + 2 + H) @(negedge clk);
    check("glitch_busy_high", {31'd0, Rx_Busy}, 32'd1);
    @(negedge clk);
    check("glitch_busy_low", {31'd0, Rx_Busy}, 32'd0);
    repeat (10) @(negedge clk);

    align();
    send_frame(8'h55, 1'b0, BIT_NS);
    #500;
    check("break_busy", {31'd0, Rx_Busy}, 32'd1);
    #500;
    RsRx = 1'b1;
    repeat (10) @(negedge clk);
    check("break_exit_busy", {31'd0, Rx_Busy}, 32'd0);
    check("cmd_after_error", {24'd0, Command}, {24'd0, model_cmd});

    align();
    send_frame(8'h12, 1'b1, BIT_NS);
    repeat (20) @(negedge clk);

    align();
    fork
      send_raw(8'hC3, 1'b1, BIT_NS);
      begin
        #(5 * BIT_NS + BIT_NS / 2);
        reset_b = 1'b0;
        model_cmd = 8'h00;
        @(posedge clk);
        @(negedge clk);
        check("midrst_command", {24'd0, Command}, 32'h00);
        check("midrst_busy", {31'd0, Rx_Busy}, 32'd0);
        check("midrst_ready", {31'd0, Rx_Ready}, 32'd0);
        check("midrst_ferr", {31'd0, Framing_Error}, 32'd0);
      end
    join
    repeat (20) @(negedge clk);
    reset_b = 1'b1;
    repeat (5) @(negedge clk);
    align();
    send_frame(8'h81, 1'b1, BIT_NS);
    repeat (20) @(negedge clk);

    align();
    send_frame(8'h6B, 1'b1, BIT_NS + 5);
    send_frame(8'h6B, 1'b1, BIT_NS - 5);
    repeat (20) @(negedge clk);

    align();
    for (int i = 0; i < 24; i++) begin
      b   = 8'($urandom);
      sel = $urandom_range(0, 2);
      gap = $urandom_range(0, 30);
      send_frame(b, 1'b1, (sel == 0) ? BIT_NS - 5 : (sel == 1) ? BIT_NS : BIT_NS + 5);
      #(gap * 10);
    end

    repeat (200) @(negedge clk);
    check("pending_frames", exp_q.size(), 32'd0);
    check("final_busy", {31'd0, Rx_Busy}, 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/uart_command_receiver.md
# uart_command_receiver

Serial receive front end for the acoustics board's host link: oversamples the UART line `RsRx`, deserialises 8N1 frames and presents each good byte as `Command` with a one-cycle `Rx_Ready` strobe. It sits directly upstream of the command reader, which decodes `Command` on `Rx_Ready`. Framing errors are flagged and never produce a strobe.

## Interface
- `CLKS_PER_BIT`, 868, clock cycles per bit (100 MHz / 115200); legal range 4..65535.
- `clk`  in  1  system clock; all logic on rising edge.
- `reset_b`  in  1  reset, synchronous and active-low.
- `RsRx`  in  1  asynchronous UART line, idle high.
- `Command`  out  8  last good byte received, LSB first on the wire; held until next good byte.
- `Rx_Ready`  out  1  one-cycle pulse; `Command` is valid in the same cycle.
- `Framing_Error`  out  1  one-cycle pulse when the stop bit samples low.
- `Rx_Busy`  out  1  high in every state except IDLE.

## Operation
- `RsRx` passes through a 2-FF synchroniser (`rx_s`), plus one history FF (`rx_d`) for edge detection.
- State machine: IDLE, START, DATA, STOP, BREAK.
- IDLE: on `rx_d`=1 and `rx_s`=0 (falling edge), clear the bit counter and go to START.
- START: count H = CLKS_PER_BIT/2 (integer division) cycles; at count end, sample `rx_s`. If 0, go to DATA with bit index 0. If 1, treat as a glitch and return to IDLE with no output pulse.
- DATA: every CLKS_PER_BIT cycles, sample `rx_s` into shift register bit [index], LSB first. After index 7, go to STOP.
- STOP: after CLKS_PER_BIT cycles, sample `rx_s`.
  - If 1: load `Command`, pulse `Rx_Ready`, return to IDLE.
  - If 0: pulse `Framing_Error`, leave `Command` unchanged, go to BREAK.
- BREAK: wait for `rx_s`=1, then go to IDLE. A held-low line therefore yields exactly one error pulse.
- Cycle counter is `$clog2(CLKS_PER_BIT)` bits wide and restarts at 0 on every state entry and every bit sample. The bit index is 3 bits.
- Receipt of the next start edge does not depend on the consumer. The block has no backpressure: a new byte overwrites `Command`.

## Timing
- Reset (`reset_b`=0 at a clock edge) produces these values:
  - State IDLE.
  - `Command`=8'h00.
  - `Rx_Ready`, `Framing_Error` and `Rx_Busy` all 0.
  - Synchroniser and history FFs = 1 (idle).
- Reset mid-frame abandons the frame with no pulse. After release, reception resumes only on a fresh falling edge.
- Let t0 be the cycle in which the edge is detected in IDLE.
  - Start sample at t0+H.
  - Data bit i sampled at t0+H+(i+1)·CLKS_PER_BIT.
  - Stop sampled at t0+H+9·CLKS_PER_BIT.
  - `Rx_Ready`/`Framing_Error` high for exactly the next cycle.
- Pin-to-t0 latency is 3 cycles: 2 synchroniser stages plus the edge register.
- `Rx_Busy` rises at t0+1 and falls in the cycle `Rx_Ready` is asserted (or on leaving BREAK).
- Back-to-back frames with zero idle after the stop bit are received without loss. IDLE is re-entered half a bit before the stop bit ends.
- `Rx_Ready` and `Framing_Error` are never high together.

## Structure
- Shared package `acoustics_uart_pkg` contains:
  - state enum `uart_rx_state_t` {IDLE, START, DATA, STOP, BREAK};
  - constant `UART_DEFAULT_CLKS_PER_BIT`=868, shared with the transmitter.
- One sub-module, `uart_rx_line_sync`: the 2-FF synchroniser plus history FF with falling-edge output. It is reset to 1 and is also reused by other asynchronous inputs.
- The top contains the FSM, counters, shift register and output registers.

## Test plan
All scenarios run with CLKS_PER_BIT=16.
- Single frame 8'hA5 at nominal baud -> `Command`=8'hA5, `Rx_Ready` high one cycle at t0+8+144+1; `Framing_Error` stays 0.
- Frames 8'h00, 8'hFF, 8'h3C sent back-to-back with no idle -> three `Rx_Ready` pulses, `Command` sequence 00, FF, 3C.
- 5-cycle low glitch on idle line -> no pulse on either output; `Rx_Busy` returns to 0 at t0+9.
- Frame 8'h55 with stop bit driven 0, then line held low 100 cycles, then released -> one `Framing_Error` pulse, `Command` keeps its prior value.
- Next valid frame 8'h12 after that error -> `Command`=8'h12 with `Rx_Ready`.
- `reset_b` pulled low during data bit 4 of 8'hC3 -> all outputs at reset values, no pulse. A following full frame 8'h81 is received correctly.
- Bit period skewed ±3% (16±0.5 cycles) for frame 8'h6B -> `Command`=8'h6B.
